// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
//   Instruction-fetch stage of the 5-stage pipeline. Owns the PC, issues
//   requests to a variable-latency instruction memory (req/ready handshake),
//   presents pc+4 and the fetched word to the IF/ID register, and applies
//   branch/jump redirects from ID with one architectural delay slot.
//
// Ports
//   clk         in   pipeline clock, rising edge
//   clr         in   asynchronous active-high reset
//   stall       in   hazard stall (same signal that freezes IF/ID)
//   pcsrc[1:0]  in   00 seq, 01 branch (bpc), 10 jump (jpc), 11 jr (rpc)
//   bpc/jpc/rpc in   redirect targets
//   imem_addr   out  fetch address (= pc)
//   imem_req    out  fetch request
//   imem_rdata  in   instruction word, valid with imem_ready
//   imem_ready  in   fetch completes this cycle
//   if_pc4      out  pc+4 to IF/ID
//   if_inst     out  instruction to IF/ID (NOP = 0 when none available)
//   if_valid    out  if_inst is a real instruction
// -----------------------------------------------------------------------------
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        stall,
  input  logic [1:0]  pcsrc,
  input  logic [31:0] bpc,
  input  logic [31:0] jpc,
  input  logic [31:0] rpc,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] if_pc4,
  output logic [31:0] if_inst,
  output logic        if_valid
);

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HOLD  = 1'b1
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_inst_buf;
  logic        r_pend;
  logic [31:0] r_pend_pc;

  state_t      w_state_nxt;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_inst_buf_nxt;
  logic        w_pend_nxt;
  logic [31:0] w_pend_pc_nxt;
  logic [31:0] w_pc4;
  logic [31:0] w_tgt;
  logic        w_avail;
  logic [31:0] w_word;
  logic        w_deliver;
  logic        w_redir;

  assign w_pc4 = r_pc + 32'd4;

  // Redirect target select; pcsrc is only honoured when the pipe is not stalled
  // because ID re-presents the same control while frozen.
  always_comb begin
    w_tgt = bpc;
    case (pcsrc)
      2'b01:   w_tgt = bpc;
      2'b10:   w_tgt = jpc;
      2'b11:   w_tgt = rpc;
      default: w_tgt = bpc;
    endcase
  end

  assign w_redir = (pcsrc != 2'b00) && !stall;

  // Next-state logic: FSM transitions, instruction buffer, PC and pending redirect.
  always_comb begin
    w_state_nxt    = r_state;
    w_inst_buf_nxt = r_inst_buf;
    w_pc_nxt       = r_pc;
    w_pend_nxt     = r_pend;
    w_pend_pc_nxt  = r_pend_pc;
    w_avail        = 1'b0;
    w_word         = 32'h0000_0000;

    case (r_state)
      S_FETCH: begin
        w_avail = imem_ready;
        w_word  = imem_rdata;
        // A word that completes while stalled is parked so the memory is not re-asked.
        if (imem_ready && stall) begin
          w_state_nxt    = S_HOLD;
          w_inst_buf_nxt = imem_rdata;
        end else begin
          w_state_nxt = S_FETCH;
        end
      end
      S_HOLD: begin
        w_avail = 1'b1;
        w_word  = r_inst_buf;
        if (!stall) begin
          w_state_nxt = S_FETCH;
        end else begin
          w_state_nxt = S_HOLD;
        end
      end
      default: begin
        w_state_nxt = S_FETCH;
      end
    endcase

    w_deliver = w_avail && !stall;

    if (w_deliver) begin
      // The word delivered now is the delay slot of any redirect seen with it.
      if (w_redir) begin
        w_pc_nxt = w_tgt;
      end else if (r_pend) begin
        w_pc_nxt = r_pend_pc;
      end else begin
        w_pc_nxt = w_pc4;
      end
      w_pend_nxt = 1'b0;
    end else if (w_redir) begin
      // Redirect arrived before its delay slot finished fetching: remember it.
      // A newer redirect overwrites an older pending one.
      w_pend_nxt    = 1'b1;
      w_pend_pc_nxt = w_tgt;
    end else begin
      w_pend_nxt = r_pend;
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state    <= S_FETCH;
      r_pc       <= RESET_PC;
      r_inst_buf <= 32'h0000_0000;
      r_pend     <= 1'b0;
      r_pend_pc  <= 32'h0000_0000;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_inst_buf <= w_inst_buf_nxt;
      r_pend     <= w_pend_nxt;
      r_pend_pc  <= w_pend_pc_nxt;
    end
  end

  // Output decode: the word reaches IF/ID in the same cycle it is available;
  // clr forces a bubble and drops the request immediately.
  always_comb begin
    imem_addr = r_pc;
    if_pc4    = w_pc4;
    imem_req  = (r_state == S_FETCH) && !clr;
    if (clr) begin
      if_inst  = 32'h0000_0000;
      if_valid = 1'b0;
    end else if (w_avail) begin
      if_inst  = w_word;
      if_valid = 1'b1;
    end else begin
      if_inst  = 32'h0000_0000;
      if_valid = 1'b0;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        clr;
  logic        stall;
  logic [1:0]  pcsrc;
  logic [31:0] bpc, jpc, rpc;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] if_pc4;
  logic [31:0] if_inst;
  logic        if_valid;

  int n_checks;
  int n_pass;

  // Reference model: a PC, an optional parked word, an optional pending target.
  logic [31:0] m_pc;
  bit          m_have;
  logic [31:0] m_buf;
  bit          m_pend;
  logic [31:0] m_pend_pc;

  if_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .clr(clr), .stall(stall), .pcsrc(pcsrc),
    .bpc(bpc), .jpc(jpc), .rpc(rpc),
    .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .if_pc4(if_pc4), .if_inst(if_inst), .if_valid(if_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  function automatic logic [31:0] pick_tgt(input logic [1:0] sel, input logic [31:0] b,
                                           input logic [31:0] j, input logic [31:0] r);
    if (sel == 2'b01) return b;
    if (sel == 2'b10) return j;
    return r;
  endfunction

  task automatic model_reset();
    m_pc = RESET_PC; m_have = 0; m_buf = 32'h0; m_pend = 0; m_pend_pc = 32'h0;
  endtask

  // One pipeline cycle: drive on the falling edge, check mid-low-phase, advance model after rise.
  task automatic step(input bit st, input logic [1:0] ps, input logic [31:0] b,
                      input logic [31:0] j, input logic [31:0] r,
                      input bit rdy, input logic [31:0] rd);
    bit          avail;
    logic [31:0] e_inst;
    @(negedge clk);
    stall = st; pcsrc = ps; bpc = b; jpc = j; rpc = r; imem_ready = rdy; imem_rdata = rd;
    #1;
    avail  = m_have || rdy;
    e_inst = m_have ? m_buf : (rdy ? rd : 32'h0);
    check("imem_addr", imem_addr, m_pc);
    check("imem_req", {31'h0, imem_req}, {31'h0, !m_have});
    check("if_pc4", if_pc4, m_pc + 32'd4);
    check("if_valid", {31'h0, if_valid}, {31'h0, avail});
    check("if_inst", if_inst, e_inst);
    @(posedge clk);
    #1;
    if (avail && !st) begin
      if (ps != 2'b00)  m_pc = pick_tgt(ps, b, j, r);
      else if (m_pend)  m_pc = m_pend_pc;
      else              m_pc = m_pc + 32'd4;
      m_have = 0;
      m_pend = 0;
    end else if (avail) begin
      if (!m_have) begin m_have = 1; m_buf = rd; end
    end else if (!st && ps != 2'b00) begin
      m_pend = 1; m_pend_pc = pick_tgt(ps, b, j, r);
    end
  endtask

  task automatic seq(input bit rdy, input logic [31:0] rd);
    step(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, rdy, rd);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must react immediately.
  task automatic do_reset();
    @(negedge clk);
    #2 clr = 1'b1;
    #1 model_reset();
    check("rst_req", {31'h0, imem_req}, 32'h0);
    check("rst_valid", {31'h0, if_valid}, 32'h0);
    check("rst_inst", if_inst, 32'h0);
    check("rst_pc4", if_pc4, RESET_PC + 32'd4);
    check("rst_addr", imem_addr, RESET_PC);
    @(posedge clk);
    @(negedge clk);
    stall = 1'b0; pcsrc = 2'b00; imem_ready = 1'b0;
    clr = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    clr = 1'b1; stall = 1'b0; pcsrc = 2'b00;
    bpc = 32'h0; jpc = 32'h0; rpc = 32'h0; imem_rdata = 32'h0; imem_ready = 1'b1;
    model_reset();
    do_reset();

    // Zero-wait memory: one instruction per cycle from 0.
    seq(1'b1, 32'h1111_0000);
    seq(1'b1, 32'h1111_0004);
    check("seq_pc8", imem_addr, 32'h0000_0008);
    // Two wait cycles at 8.
    seq(1'b0, 32'hDEAD_BEEF);
    seq(1'b0, 32'hDEAD_BEEF);
    check("wait_hold8", imem_addr, 32'h0000_0008);
    seq(1'b1, 32'h1111_0008);
    check("after_wait_c", imem_addr, 32'h0000_000C);
    // Stall while word at C arrives, then release.
    step(1'b1, 2'b00, 32'h0, 32'h0, 32'h0, 1'b1, 32'h8C22_0004);
    check("hold_req", {31'h0, imem_req}, 32'h0);
    check("hold_inst", if_inst, 32'h8C22_0004);
    step(1'b1, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    step(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    check("hold_rel_10", imem_addr, 32'h0000_0010);
    seq(1'b1, 32'h1111_0010);
    // Branch delivered with the word at 14.
    step(1'b0, 2'b01, 32'h0000_0040, 32'h0, 32'h0, 1'b1, 32'h1111_0014);
    check("branch_40", imem_addr, 32'h0000_0040);
    // jr to 20.
    step(1'b0, 2'b11, 32'h0, 32'h0, 32'h0000_0020, 1'b1, 32'h1111_0040);
    // Jump while fetch at 20 waits three cycles.
    step(1'b0, 2'b10, 32'h0, 32'h0000_0100, 32'h0, 1'b0, 32'h0);
    seq(1'b0, 32'h0);
    seq(1'b0, 32'h0);
    check("pend_hold20", imem_addr, 32'h0000_0020);
    seq(1'b1, 32'h1111_0020);
    check("pend_jump_100", imem_addr, 32'h0000_0100);
    // Branch to 30, then reset while waiting there.
    step(1'b0, 2'b01, 32'h0000_0030, 32'h0, 32'h0, 1'b1, 32'h1111_0100);
    seq(1'b0, 32'h0);
    step(1'b0, 2'b10, 32'h0, 32'h0000_0200, 32'h0, 1'b0, 32'h0);
    do_reset();
    seq(1'b1, 32'h2222_0000);
    check("restart_4", imem_addr, 32'h0000_0004);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        step(($urandom_range(0, 3) == 0),
             ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
             $urandom, $urandom, $urandom,
             ($urandom_range(0, 9) < 7), $urandom);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
